sample_capture_player: RTL and testbench
========================================

# sample_capture_player

Parametrised one-shot sample recorder and slow-playback engine for the board bring-up path. It waits for a non-zero input word, decimates the input stream by a fixed divider into an on-chip buffer, then replays a slice of each stored word at a human-visible rate onto LED outputs. Playback can be one-shot or looping. The block sits between the SD/ADC-style data source and the board LED bank.

## Interface
- `DATA_W`, 8, input sample width
- `DEPTH`, 4096, buffer entries (≥2); `ADDR_W` = $clog2(DEPTH) is a localparam
- `CAP_DIV`, 96, clocks per captured sample (≥2)
- `PLAY_DIV`, 1000000, clocks per played sample (≥2)
- `OUT_W`, 4, played bits per sample (≤DATA_W), taken from the LSBs
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `din`  in  DATA_W  live sample input
- `arm`  in  1  single-cycle pulse; restarts the block at WAIT_TRIG
- `loop`  in  1  0 = one-shot playback, 1 = wrap playback; sampled at every end-of-buffer
- `dout`  out  OUT_W  played sample (LED drive)
- `capturing`  out  1  high in CAPTURE
- `playing`  out  1  high in PLAY
- `done`  out  1  high in DONE
- `wr_count`  out  ADDR_W+1  samples stored since the last trigger

## Operation
- States: WAIT_TRIG, CAPTURE, PLAY, DONE. Reset and `arm` both enter WAIT_TRIG and clear both dividers, `wr_ptr`, `rd_ptr`, `wr_count` and `dout`.
- Priority: `rst` > `arm` > state logic. If `arm` and a trigger occur in the same cycle, the trigger is ignored.
- WAIT_TRIG: when `din != 0`, go to CAPTURE next cycle and clear the capture divider. That cycle itself writes nothing.
- CAPTURE: the divider counts 0..CAP_DIV-1. At count CAP_DIV-1 the block writes `din` to mem[`wr_ptr`] and increments `wr_ptr` and `wr_count`. After write index DEPTH-1, go to PLAY with `rd_ptr`=0 and the play divider at 0.
- PLAY: an internal register `rd_data` continuously loads mem[`rd_ptr`] (one-cycle synchronous read). At play-divider count PLAY_DIV-1:
  - `dout` <= `rd_data[OUT_W-1:0]` and `rd_ptr` increments.
  - When `rd_ptr` is DEPTH-1 at that strobe: if `loop`=1, `rd_ptr` wraps to 0 and PLAY continues; if `loop`=0, go to DONE.
- DONE: `dout` holds the last played value. Only `arm` or `rst` leaves DONE.
- The memory holds no reset; stale contents are never played because playback follows a full capture.

## Timing
- Reset values: `dout`=0, `capturing`=0, `playing`=0, `done`=0, `wr_count`=0, state=WAIT_TRIG.
- Status outputs are registered and decode the current state.
- Trigger seen at cycle T: `capturing`=1 from T+1. The first write uses `din` at cycle T+CAP_DIV, and `wr_count` reads 1 at T+CAP_DIV+1.
- Sample k (0-based) is `din` at cycle T+(k+1)·CAP_DIV.
- Last write at cycle W: `playing`=1 at W+1. The first `dout` update is visible at W+PLAY_DIV+1.
- Subsequent `dout` updates come every PLAY_DIV cycles. PLAY_DIV ≥ 2 guarantees `rd_data` is valid at each strobe.
- One-shot: `done`=1 on the cycle after the final `dout` update.
- `wr_count` saturates at DEPTH, which is why it is ADDR_W+1 bits wide.

## Configuration
- `SCP_LIVE_EN` defined: in WAIT_TRIG and CAPTURE, `dout` <= `din[OUT_W-1:0]` every cycle (one-cycle registered monitor). PLAY and DONE are unchanged.
- `SCP_LIVE_EN` undefined: `dout` stays 0 in WAIT_TRIG and CAPTURE. This mode is required when the LEDs must stay dark until playback starts.

## Test plan
Bench parameters: DEPTH=8, CAP_DIV=4, PLAY_DIV=3, OUT_W=4.

- Reset, then `din`=0 for 50 cycles -> state stays WAIT_TRIG, `wr_count`=0, `dout`=0, all flags low.
- `din` ramps 1,2,3… each cycle starting at trigger cycle T -> stored words equal `din` at T+4, T+8, …, T+32. `playing` rises at T+33. `dout` shows the stored LSB nibbles at T+36, T+39, …, and `done` rises after the 8th update when `loop`=0.
- Same stimulus with `loop`=1 -> after the 8th value, `dout` restarts with the first stored value 3 cycles later and `done` never rises. Clearing `loop` mid-run ends playback at the next end-of-buffer.
- `arm` pulsed mid-CAPTURE with `wr_count`=3 -> next cycle WAIT_TRIG, `wr_count`=0, `capturing`=0. A fresh trigger then restarts the capture from index 0.
- `rst` asserted during PLAY, and `arm` asserted together with `din`≠0 in WAIT_TRIG -> all outputs return to reset values, and no trigger is taken in the `arm` cycle.
- With `SCP_LIVE_EN` defined, `din`=0x5A in CAPTURE -> `dout`=0xA one cycle later. Without the macro -> `dout`=0.

Source files
------------

// File: rtl/sample_capture_player_if.sv
// Handshake/status bundle between the capture/playback engine and its driver.
// master drives the sample stream and controls; slave is the engine itself.
interface sample_capture_player_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 4,
  parameter int CNT_W  = 13
) ();
  logic [DATA_W-1:0] din;
  logic              arm;
  logic              loop;
  logic [OUT_W-1:0]  dout;
  logic              capturing;
  logic              playing;
  logic              done;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output din, arm, loop,
    input  dout, capturing, playing, done, wr_count
  );

  modport slave (
    input  din, arm, loop,
    output dout, capturing, playing, done, wr_count
  );
endinterface

// File: rtl/sample_capture_player.sv
// One-shot sample recorder with decimated capture and slow (optionally looping) LED playback.
// Optional macro SCP_LIVE_EN: mirror live din LSBs onto dout while waiting/capturing.
module sample_capture_player #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4096,
  parameter int CAP_DIV  = 96,
  parameter int PLAY_DIV = 1000000,
  parameter int OUT_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sample_capture_player_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CDIV_W = $clog2(CAP_DIV);
  localparam int PDIV_W = $clog2(PLAY_DIV);

  typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, PLAY, DONE} state_t;

  state_t              state;
  logic [CDIV_W-1:0]   cap_div;
  logic [PDIV_W-1:0]   play_div;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     wr_count;
  logic [OUT_W-1:0]    dout;
  logic                capturing;
  logic                playing;
  logic                done;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data;
  logic                cap_stb;
  logic                play_stb;
  logic                wr_last;
  logic                rd_last;
  logic                wr_en;

  assign cap_stb  = (cap_div == CDIV_W'(CAP_DIV - 1));
  assign play_stb = (play_div == PDIV_W'(PLAY_DIV - 1));
  assign wr_last  = (wr_ptr == ADDR_W'(DEPTH - 1));
  assign rd_last  = (rd_ptr == ADDR_W'(DEPTH - 1));
  assign wr_en    = (state == CAPTURE) && cap_stb && !rst && !bus.arm;

  // Buffer: no reset, playback only ever follows a complete capture
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.din;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.arm) begin
      state     <= WAIT_TRIG;
      cap_div   <= '0;
      play_div  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_count  <= '0;
      dout      <= '0;
      capturing <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        WAIT_TRIG: begin
`ifdef SCP_LIVE_EN
          dout <= bus.din[OUT_W-1:0];
`endif
          if (bus.din != '0) begin
            state     <= CAPTURE;
            capturing <= 1'b1;
            cap_div   <= '0;
          end
        end

        CAPTURE: begin
`ifdef SCP_LIVE_EN
          dout <= bus.din[OUT_W-1:0];
`endif
          if (cap_stb) begin
            cap_div <= '0;
            wr_ptr  <= wr_last ? '0 : wr_ptr + ADDR_W'(1);
            if (wr_count != (ADDR_W+1)'(DEPTH))
              wr_count <= wr_count + (ADDR_W+1)'(1);
            if (wr_last) begin
              state     <= PLAY;
              capturing <= 1'b0;
              playing   <= 1'b1;
              rd_ptr    <= '0;
              play_div  <= '0;
            end
          end else begin
            cap_div <= cap_div + CDIV_W'(1);
          end
        end

        // rd_data has settled at least one cycle before each strobe since PLAY_DIV >= 2
        PLAY: begin
          if (play_stb) begin
            play_div <= '0;
            dout     <= rd_data[OUT_W-1:0];
            if (rd_last) begin
              rd_ptr <= '0;
              if (!bus.loop) begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end else begin
            play_div <= play_div + PDIV_W'(1);
          end
        end

        DONE: begin
        end

        default: state <= WAIT_TRIG;
      endcase
    end
  end

  assign bus.dout      = dout;
  assign bus.capturing = capturing;
  assign bus.playing   = playing;
  assign bus.done      = done;
  assign bus.wr_count  = wr_count;

endmodule

// File: tb/tb_sample_capture_player.sv
// Directed bench for sample_capture_player with DEPTH=8, CAP_DIV=4, PLAY_DIV=3, OUT_W=4.
module tb_sample_capture_player;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int CAP_DIV  = 4;
  localparam int PLAY_DIV = 3;
  localparam int OUT_W    = 4;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef SCP_LIVE_EN
  localparam logic [3:0] LIVE_EXP = 4'hA;
`else
  localparam logic [3:0] LIVE_EXP = 4'h0;
`endif

  sample_capture_player_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  sample_capture_player #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CAP_DIV(CAP_DIV),
    .PLAY_DIV(PLAY_DIV), .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"},  32'(bus.dout), 32'd0);
    chk({tag, "_cap"},   32'(bus.capturing), 32'd0);
    chk({tag, "_play"},  32'(bus.playing), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_wrcnt"}, 32'(bus.wr_count), 32'd0);
  endtask

  // Drives din = base + c at trigger-relative cycle c; stored sample k = base + 4k + 4
  task automatic run_ramp(input logic [7:0] base, input int n_cyc, input int n_upd,
                          input int clr_at);
    int t, j;
    logic [7:0] smp;
    for (int c = 0; c < n_cyc; c++) begin
      bus.din = base + 8'(c);
      if (c == clr_at) bus.loop = 1'b0;
      tick();
      t = c + 1;
      if (t == 1) chk("cap_rise", 32'(bus.capturing), 32'd1);
      if (t == 5) chk("wr_cnt_1", 32'(bus.wr_count), 32'd1);
      if (t == 32) chk("play_low_pre", 32'(bus.playing), 32'd0);
      if (t == 33) begin
        chk("play_rise", 32'(bus.playing), 32'd1);
        chk("cap_fall", 32'(bus.capturing), 32'd0);
        chk("wr_cnt_sat", 32'(bus.wr_count), 32'(DEPTH));
      end
      if (t >= 36 && ((t - 36) % 3) == 0 && ((t - 36) / 3) < n_upd) begin
        j   = (t - 36) / 3;
        smp = base + 8'(4 * (j % 8) + 4);
        chk($sformatf("dout_upd%0d", j), 32'(bus.dout), 32'(smp & 8'h0F));
      end
    end
  endtask

  task automatic pulse_arm(input logic [7:0] d);
    bus.arm = 1'b1;
    bus.din = d;
    tick();
    bus.arm = 1'b0;
    bus.din = 8'h00;
  endtask

  initial begin
    bus.din  = 8'h00;
    bus.arm  = 1'b0;
    bus.loop = 1'b0;
    rst      = 1'b1;
    repeat (3) tick();
    chk_idle("reset");
    rst = 1'b0;

    // Idle with zero input: must never trigger
    repeat (50) tick();
    chk_idle("idle50");

    // One-shot capture and playback, samples 5,9,..,33 -> nibbles 5,9,D,1,5,9,D,1
    run_ramp(8'h01, 56, 7, -1);
    chk("os_done_pre", 32'(bus.done), 32'd0);
    tick();
    chk("os_dout_last", 32'(bus.dout), 32'h1);
    chk("os_done", 32'(bus.done), 32'd1);
    chk("os_play_off", 32'(bus.playing), 32'd0);
    repeat (5) tick();
    chk("os_dout_hold", 32'(bus.dout), 32'h1);
    chk("os_done_hold", 32'(bus.done), 32'd1);

    pulse_arm(8'h00);
    chk_idle("rearm");

    // Looping playback, samples 0x27..0x43 -> nibbles 7,B,F,3,7,B,F,3; loop cleared mid second pass
    bus.loop = 1'b1;
    run_ramp(8'h23, 80, 15, 65);
    chk("loop_done_pre", 32'(bus.done), 32'd0);
    chk("loop_playing", 32'(bus.playing), 32'd1);
    tick();
    chk("loop_dout_last", 32'(bus.dout), 32'h3);
    chk("loop_done", 32'(bus.done), 32'd1);

    // Arm during capture with three samples stored
    pulse_arm(8'h00);
    run_ramp(8'h01, 13, 0, -1);
    chk("mid_wrcnt3", 32'(bus.wr_count), 32'd3);
    pulse_arm(8'h00);
    chk("mid_cap_off", 32'(bus.capturing), 32'd0);
    chk("mid_wrcnt0", 32'(bus.wr_count), 32'd0);

    // Fresh capture from index 0 (samples 0x54, 0x58, ...), then reset during PLAY
    run_ramp(8'h50, 40, 2, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_play");

    // arm together with a trigger value: trigger must be ignored
    pulse_arm(8'h77);
    chk("armtrig_cap0", 32'(bus.capturing), 32'd0);
    tick();
    chk("armtrig_cap1", 32'(bus.capturing), 32'd0);
    chk("armtrig_wrcnt", 32'(bus.wr_count), 32'd0);

    // Live monitor during capture
    bus.din = 8'h01;
    tick();
    bus.din = 8'h5A;
    tick();
    chk("live_cap", 32'(bus.capturing), 32'd1);
    chk("live_dout", 32'(bus.dout), 32'(LIVE_EXP));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
